// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, field widths and refresh FSM states.
// The init, read and write command blocks import the same definitions.
package sdram_pkg;

  localparam int unsigned CMD_CTRL_W = 4;
  localparam int unsigned DEBT_W     = 4;
  localparam int unsigned A10_BIT    = 10;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_CTRL_W-1:0] CTRL_NOP = 4'b0111;
  localparam logic [CMD_CTRL_W-1:0] CTRL_PRE = 4'b0010;
  localparam logic [CMD_CTRL_W-1:0] CTRL_REF = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_TRP_W,
    ST_REF,
    ST_TRFC_W,
    ST_DONE
  } ref_state_e;

endpackage

// File: rtl/sdram_ref_sched_if.sv
// Refresh scheduler <-> arbiter bundle; master is the scheduler side.
interface sdram_ref_sched_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BA_W   = 2
);
  import sdram_pkg::*;

  logic                             ini_end;
  logic                             ref_en;
  logic                             ref_req;
  logic                             ref_urgent;
  logic [CMD_CTRL_W+BA_W+ADDR_W-1:0] ref_cmd;
  logic                             ref_end;
  logic                             ref_busy;
  logic [DEBT_W-1:0]                ref_debt;
  logic                             ref_overflow;

  modport master (
    input  ini_end, ref_en,
    output ref_req, ref_urgent, ref_cmd, ref_end, ref_busy, ref_debt, ref_overflow
  );

  modport slave (
    output ini_end, ref_en,
    input  ref_req, ref_urgent, ref_cmd, ref_end, ref_busy, ref_debt, ref_overflow
  );
endinterface

// File: rtl/sdram_ref_timer.sv
// Refresh interval counter; tick is high during the wrap cycle of each interval.
module sdram_ref_timer #(
  parameter int unsigned REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(REF_INTERVAL);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // Tick is registered one count early so it lines up with the wrap cycle.
  always_comb begin
    count_d = '0;
    tick_d  = 1'b0;
    if (enable) begin
      if (count_q != CNT_W'(REF_INTERVAL - 1)) count_d = count_q + CNT_W'(1);
      tick_d = (count_q == CNT_W'(REF_INTERVAL - 2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sdram_ref_sched.sv
// SDRAM auto-refresh scheduler: accumulates refresh debt, requests the arbiter,
// and on grant issues optional PRECHARGE-ALL then one or a burst of AUTO REFRESH.
module sdram_ref_sched
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W        = 12,
  parameter int unsigned BA_W          = 2,
  parameter int unsigned REF_INTERVAL  = 780,
  parameter int unsigned MAX_DEBT      = 8,
  parameter int unsigned URGENT_THRESH = 6,
  parameter int unsigned TRP_CYC       = 3,
  parameter int unsigned TRFC_CYC      = 10,
  parameter int unsigned PRE_EN        = 1,
  parameter int unsigned BURST_MODE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  sdram_ref_sched_if.master bus
);

  localparam int unsigned CMD_W    = CMD_CTRL_W + BA_W + ADDR_W;
  localparam int unsigned WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [ADDR_W-1:0] A10_MASK = ADDR_W'(1 << A10_BIT);
  localparam logic [CMD_W-1:0]  CMD_NOP  = {CTRL_NOP, {BA_W{1'b0}}, {ADDR_W{1'b0}}};
  localparam logic [CMD_W-1:0]  CMD_PRE  = {CTRL_PRE, {BA_W{1'b0}}, A10_MASK};
  localparam logic [CMD_W-1:0]  CMD_REF  = {CTRL_REF, {BA_W{1'b0}}, {ADDR_W{1'b0}}};

  ref_state_e        state_q, state_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              req_q, req_d;
  logic              urgent_q, urgent_d;
  logic              busy_q, busy_d;
  logic              end_q, end_d;
  logic              ovf_q, ovf_d;
  logic              tick;
  logic              accept;
  logic              issue;

  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (bus.ini_end),
    .tick   (tick)
  );

  assign accept = (state_q == ST_IDLE) && bus.ref_en && req_q;
  assign issue  = (state_q == ST_REF);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    debt_d  = debt_q;
    ovf_d   = ovf_q;

    // A credit and a REF in the same cycle cancel out.
    if (tick && !issue) begin
      if (debt_q == DEBT_W'(MAX_DEBT)) ovf_d = 1'b1;
      else                             debt_d = debt_q + DEBT_W'(1);
    end else if (!tick && issue) begin
      debt_d = debt_q - DEBT_W'(1);
    end

    case (state_q)
      ST_IDLE:   if (accept) state_d = (PRE_EN != 0) ? ST_PRE : ST_REF;
      ST_PRE: begin
        wait_d  = '0;
        state_d = (TRP_CYC > 1) ? ST_TRP_W : ST_REF;
      end
      ST_TRP_W: begin
        if (wait_q == WAIT_W'(TRP_CYC - 2)) state_d = ST_REF;
        else                                wait_d  = wait_q + WAIT_W'(1);
      end
      ST_REF: begin
        wait_d  = '0;
        state_d = ST_TRFC_W;
      end
      // Burst continuation sees credits that landed during the wait.
      ST_TRFC_W: begin
        if (wait_q == WAIT_W'(TRFC_CYC - 2))
          state_d = ((BURST_MODE != 0) && (debt_d != '0)) ? ST_REF : ST_DONE;
        else
          wait_d = wait_q + WAIT_W'(1);
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    req_d    = (state_q == ST_IDLE) && (debt_q != '0) && !accept;
    urgent_d = (debt_d >= DEBT_W'(URGENT_THRESH));
    busy_d   = (state_d != ST_IDLE);
    end_d    = (state_d == ST_DONE);
    cmd_d    = CMD_NOP;
    if (state_d == ST_PRE)      cmd_d = CMD_PRE;
    else if (state_d == ST_REF) cmd_d = CMD_REF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      debt_q   <= '0;
      wait_q   <= '0;
      cmd_q    <= CMD_NOP;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      debt_q   <= debt_d;
      wait_q   <= wait_d;
      cmd_q    <= cmd_d;
      req_q    <= req_d;
      urgent_q <= urgent_d;
      busy_q   <= busy_d;
      end_q    <= end_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ref_req      = req_q;
  assign bus.ref_urgent   = urgent_q;
  assign bus.ref_cmd      = cmd_q;
  assign bus.ref_end      = end_q;
  assign bus.ref_busy     = busy_q;
  assign bus.ref_debt     = debt_q;
  assign bus.ref_overflow = ovf_q;

endmodule

// File: tb/tb_sdram_ref_sched.sv
// Bench for sdram_ref_sched: step table on a PRE_EN=0 instance, plus a command
// scoreboard over three differently configured instances.
module tb_sdram_ref_sched;

  localparam int unsigned AW = 12;
  localparam int unsigned BW = 2;
  localparam int unsigned CW = 4 + BW + AW;

  localparam logic [CW-1:0] NOP = {4'b0111, 2'b00, 12'h000};
  localparam logic [CW-1:0] PRE = {4'b0010, 2'b00, 12'h400};
  localparam logic [CW-1:0] REF = {4'b0001, 2'b00, 12'h000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  sdram_ref_sched_if #(.ADDR_W(AW), .BA_W(BW)) if_a(), if_b(), if_c();

  logic tie_a = 1'b0;
  logic en_a  = 1'b0;
  assign if_a.ref_en = tie_a ? if_a.ref_req : en_a;

  sdram_ref_sched #(.ADDR_W(AW), .BA_W(BW), .REF_INTERVAL(20), .MAX_DEBT(8),
    .URGENT_THRESH(6), .TRP_CYC(3), .TRFC_CYC(10), .PRE_EN(0), .BURST_MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.master));

  sdram_ref_sched #(.ADDR_W(AW), .BA_W(BW), .REF_INTERVAL(20), .MAX_DEBT(8),
    .URGENT_THRESH(6), .TRP_CYC(3), .TRFC_CYC(10), .PRE_EN(1), .BURST_MODE(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

  sdram_ref_sched #(.ADDR_W(AW), .BA_W(BW), .REF_INTERVAL(40), .MAX_DEBT(8),
    .URGENT_THRESH(6), .TRP_CYC(3), .TRFC_CYC(10), .PRE_EN(0), .BURST_MODE(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.master));

  typedef struct {
    logic          rst;
    logic          ini;
    logic          en;
    int            n;
    logic [3:0]    debt;
    logic          req;
    logic          urg;
    logic          busy;
    logic          endp;
    logic          ovf;
    logic [CW-1:0] cmd;
  } vec_t;

  typedef struct {
    int            cyc;
    int            id;
    logic [CW-1:0] cmd;
    logic          endp;
  } ev_t;

  vec_t vq[$];
  ev_t  exp_q[$];
  logic sb_on = 1'b0;

  function automatic vec_t mk(logic r, logic i, logic e, int n, int d, logic q,
                              logic u, logic b, logic ep, logic o, logic [CW-1:0] c);
    vec_t v;
    v.rst = r; v.ini = i; v.en = e; v.n = n; v.debt = 4'(d); v.req = q;
    v.urg = u; v.busy = b; v.endp = ep; v.ovf = o; v.cmd = c;
    return v;
  endfunction

  task automatic chk(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(int id, int c, logic [CW-1:0] cmd, logic ep);
    ev_t e;
    e.cyc = c; e.id = id; e.cmd = cmd; e.endp = ep;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Scoreboard: every non-NOP command or ref_end pulse must match the next expected event.
  always @(negedge clk) begin
    if (sb_on) begin
      for (int id = 0; id < 3; id++) begin
        logic [CW-1:0] cmd;
        logic          ep;
        case (id)
          0:       begin cmd = if_a.ref_cmd; ep = if_a.ref_end; end
          1:       begin cmd = if_b.ref_cmd; ep = if_b.ref_end; end
          default: begin cmd = if_c.ref_cmd; ep = if_c.ref_end; end
        endcase
        if (cmd != NOP || ep) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: dut%0d cyc=%0d cmd=%h end=%b, none expected",
                     id, cyc, cmd, ep);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.id != id || e.cmd != cmd || e.endp != ep) begin
              n_err++;
              $display("FAIL sb_event: got dut%0d cyc=%0d cmd=%h end=%b expected dut%0d cyc=%0d cmd=%h end=%b",
                       id, cyc, cmd, ep, e.id, e.cyc, e.cmd, e.endp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int c;
    if_a.ini_end = 1'b0;
    if_b.ini_end = 1'b0; if_b.ref_en = 1'b0;
    if_c.ini_end = 1'b0; if_c.ref_en = 1'b0;

    // Grant ignored without request, tick aligned with REF, ref_en pulsed in TRFC_W.
    vq.push_back(mk(1,0,0, 2, 0,0,0,0,0,0, NOP));
    vq.push_back(mk(0,0,1, 5, 0,0,0,0,0,0, NOP));
    vq.push_back(mk(0,1,0,58, 2,1,0,0,0,0, NOP));
    vq.push_back(mk(0,1,1, 1, 2,0,0,1,0,0, REF));
    vq.push_back(mk(0,1,0, 1, 2,0,0,1,0,0, NOP));
    vq.push_back(mk(0,1,1, 4, 2,0,0,1,0,0, NOP));
    vq.push_back(mk(0,1,0, 5, 2,0,0,1,1,0, NOP));
    vq.push_back(mk(0,1,0, 1, 2,0,0,0,0,0, NOP));
    vq.push_back(mk(0,1,0, 1, 2,1,0,0,0,0, NOP));
    // Debt accumulation, urgency, saturation and sticky overflow; ini_end drop keeps debt.
    vq.push_back(mk(1,0,0, 2, 0,0,0,0,0,0, NOP));
    vq.push_back(mk(0,1,0,21, 1,1,0,0,0,0, NOP));
    vq.push_back(mk(0,1,0,79, 5,1,0,0,0,0, NOP));
    vq.push_back(mk(0,1,0,20, 6,1,1,0,0,0, NOP));
    vq.push_back(mk(0,1,0,40, 8,1,1,0,0,0, NOP));
    vq.push_back(mk(0,1,0,20, 8,1,1,0,0,1, NOP));
    vq.push_back(mk(0,0,0,50, 8,1,1,0,0,1, NOP));
    vq.push_back(mk(0,0,1, 1, 8,0,1,1,0,1, REF));
    vq.push_back(mk(0,0,0, 1, 7,0,1,1,0,1, NOP));
    vq.push_back(mk(0,0,0, 9, 7,0,1,1,1,1, NOP));
    vq.push_back(mk(0,0,0, 1, 7,0,1,0,0,1, NOP));
    vq.push_back(mk(0,0,0, 1, 7,1,1,0,0,1, NOP));

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      rst = v.rst; if_a.ini_end = v.ini; en_a = v.en;
      repeat (v.n) @(posedge clk);
      #1;
      n_vec++;
      if (if_a.ref_debt !== v.debt || if_a.ref_req !== v.req || if_a.ref_urgent !== v.urg ||
          if_a.ref_busy !== v.busy || if_a.ref_end !== v.endp || if_a.ref_overflow !== v.ovf ||
          if_a.ref_cmd !== v.cmd) begin
        n_err++;
        $display("FAIL row%0d: got debt=%0d req=%b urg=%b busy=%b end=%b ovf=%b cmd=%h expected debt=%0d req=%b urg=%b busy=%b end=%b ovf=%b cmd=%h",
                 i, if_a.ref_debt, if_a.ref_req, if_a.ref_urgent, if_a.ref_busy, if_a.ref_end,
                 if_a.ref_overflow, if_a.ref_cmd, v.debt, v.req, v.urg, v.busy, v.endp, v.ovf, v.cmd);
      end
    end

    // Asynchronous reset while in TRFC_W with overflow set.
    en_a = 1'b1;
    @(posedge clk); #1;
    en_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_before", int'(if_a.ref_busy), 1);
    chk("t6_debt_before", int'(if_a.ref_debt), 6);
    #2 rst = 1'b1;
    #1;
    chk("t6_cmd_async",  int'(if_a.ref_cmd), int'(NOP));
    chk("t6_debt_async", int'(if_a.ref_debt), 0);
    chk("t6_ovf_async",  int'(if_a.ref_overflow), 0);
    chk("t6_busy_async", int'(if_a.ref_busy), 0);
    chk("t6_urg_async",  int'(if_a.ref_urgent), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_busy_after", int'(if_a.ref_busy), 0);
    chk("t6_cmd_after",  int'(if_a.ref_cmd), int'(NOP));
    chk("t6_req_after",  int'(if_a.ref_req), 0);

    sb_on = 1'b1;

    // Single REF with ref_en tied to ref_req.
    do_reset();
    c = cyc;
    tie_a = 1'b1;
    if_a.ini_end = 1'b1;
    push(0, c + 22, REF, 1'b0);
    push(0, c + 32, NOP, 1'b1);
    k = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      k = j;
      if (if_a.ref_req) break;
    end
    chk("t1_req_latency", k, 21);
    while (cyc < c + 33) begin
      @(posedge clk); #1;
    end
    chk("t1_debt_end", int'(if_a.ref_debt), 0);
    tie_a = 1'b0;
    if_a.ini_end = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t1_sb_drained", exp_q.size(), 0);

    // PRECHARGE-ALL before REF.
    do_reset();
    if_b.ini_end = 1'b1;
    k = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      k = j;
      if (if_b.ref_req) break;
    end
    chk("t2_req_latency", k, 21);
    c = cyc;
    if_b.ref_en = 1'b1;
    push(1, c + 1,  PRE, 1'b0);
    push(1, c + 4,  REF, 1'b0);
    push(1, c + 14, NOP, 1'b1);
    @(posedge clk); #1;
    if_b.ref_en = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    if_b.ini_end = 1'b0;
    chk("t2_sb_drained", exp_q.size(), 0);
    chk("t2_debt_end", int'(if_b.ref_debt), 0);

    // Burst drain of three credits on one grant.
    do_reset();
    if_c.ini_end = 1'b1;
    k = 0;
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
      k = j;
      if (if_c.ref_debt == 4'd3) break;
    end
    chk("t3_debt3_latency", k, 120);
    c = cyc;
    if_c.ref_en = 1'b1;
    push(2, c + 1,  REF, 1'b0);
    push(2, c + 11, REF, 1'b0);
    push(2, c + 21, REF, 1'b0);
    push(2, c + 31, NOP, 1'b1);
    @(posedge clk); #1;
    if_c.ref_en = 1'b0;
    while (cyc < c + 32) begin
      @(posedge clk); #1;
    end
    chk("t3_debt_end", int'(if_c.ref_debt), 0);
    chk("t3_busy_end", int'(if_c.ref_busy), 0);
    if_c.ini_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_sb_drained", exp_q.size(), 0);

    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
